// File: rtl/uart_text_buffer.sv
// uart_text_buffer: turns the UART byte stream into a COLS x ROWS character grid with a cursor,
// a few control codes and a registered read port for the glyph renderer.
module uart_text_buffer #(
    parameter int COLS   = 40,
    parameter int ROWS   = 15,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic [ADDR_W-1:0] o_cursor_col,
    output logic [ADDR_W-1:0] o_cursor_row,
    output logic              o_busy,
    output logic              o_overflow,
    input  logic              i_ovf_clr
);
    localparam int CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

    state_t state, state_nx;
    logic [ADDR_W-1:0] col, col_nx, row, row_nx, clr, clr_nx;
    logic [ADDR_W-1:0] row_base, next_row, waddr;
    logic              pend_v, consume, capture, we;
    logic [7:0]        pend_d, wdata;
    logic [7:0]        mem [CELLS];

    assign consume      = state == IDLE && pend_v;
    assign capture      = i_byte_valid && (!pend_v || consume);
    assign row_base     = row * COLS_A;
    assign next_row     = (row == LAST_ROW) ? '0 : row + ONE;
    assign o_busy       = state != IDLE;
    assign o_cursor_col = col;
    assign o_cursor_row = row;

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        clr_nx   = clr;
        we       = 1'b0;
        waddr    = row_base + col;
        wdata    = SPACE;
        case (state)
            CLEAR_ROW: begin
                we     = 1'b1;
                waddr  = row_base + clr;
                clr_nx = (clr == LAST_COL) ? '0 : clr + ONE;
                state_nx = (clr == LAST_COL) ? IDLE : CLEAR_ROW;
            end
            CLEAR_ALL: begin
                we     = 1'b1;
                waddr  = clr;
                clr_nx = (clr == LAST_CELL) ? '0 : clr + ONE;
                state_nx = (clr == LAST_CELL) ? IDLE : CLEAR_ALL;
            end
            default: begin
                if (consume) begin
                    if (pend_d >= 8'h20 && pend_d <= 8'h7E) begin
                        we    = 1'b1;
                        wdata = pend_d;
                        // Writing the last column wraps to a freshly cleared next row.
                        if (col == LAST_COL) begin
                            col_nx   = '0;
                            row_nx   = next_row;
                            state_nx = CLEAR_ROW;
                        end else begin
                            col_nx = col + ONE;
                        end
                    end else if (pend_d == 8'h0A) begin
                        col_nx   = '0;
                        row_nx   = next_row;
                        state_nx = CLEAR_ROW;
                    end else if (pend_d == 8'h0D) begin
                        col_nx = '0;
                    end else if (pend_d == 8'h08 && col != '0) begin
                        col_nx = col - ONE;
                        we     = 1'b1;
                        waddr  = row_base + col - ONE;
                    end else if (pend_d == 8'h0C) begin
                        col_nx   = '0;
                        row_nx   = '0;
                        state_nx = CLEAR_ALL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ALL;
            clr        <= '0;
            col        <= '0;
            row        <= '0;
            pend_v     <= 1'b0;
            pend_d     <= '0;
            o_overflow <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            state      <= state_nx;
            clr        <= clr_nx;
            col        <= col_nx;
            row        <= row_nx;
            pend_v     <= capture || (pend_v && !consume);
            pend_d     <= capture ? i_byte : pend_d;
            o_overflow <= (i_byte_valid && !capture) || (o_overflow && !i_ovf_clr);
            o_rd_data  <= mem[i_rd_addr];
        end
    end

    // RAM is never reset; the CLEAR_ALL pass that follows reset initialises it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: tb/tb_uart_text_buffer.sv
// tb_uart_text_buffer: random stimulus against a grid/cursor reference model with a
// queue-based scoreboard checked by an independent monitor process.
module tb_uart_text_buffer;
    localparam int COLS = 40;
    localparam int ROWS = 15;
    localparam int AW = 10;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bv = 1'b0;
    logic ovf_clr = 1'b0;
    logic [7:0] b = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [AW-1:0] ccol, crow;
    logic busy, ovf;

    always #5 clk = ~clk;

    uart_text_buffer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_byte_valid(bv), .i_byte(b), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_cursor_col(ccol), .o_cursor_row(crow), .o_busy(busy),
        .o_overflow(ovf), .i_ovf_clr(ovf_clr)
    );

    typedef struct {
        bit rd_chk;
        int rd;
        int col;
        int row;
        int busy;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    logic [7:0] m_mem [CELLS];
    int m_col, m_row, m_left;
    bit m_pv, m_ovf;
    logic [7:0] m_pd;

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void fill(int base, int n);
        for (int i = 0; i < n; i++) m_mem[base + i] = 8'h20;
    endfunction

    function automatic void m_reset();
        m_col = 0; m_row = 0; m_pv = 0; m_ovf = 0; m_pd = '0;
        m_left = CELLS;
        fill(0, CELLS);
    endfunction

    function automatic void newline();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        fill(m_row * COLS, COLS);
        m_left = COLS;
    endfunction

    // One clock of the model: a clear in progress just burns a cycle, otherwise a pending byte is interpreted.
    function automatic void m_step(bit v, logic [7:0] d, bit clr);
        bit cons = (m_left == 0) && m_pv;
        bit cap = v && (!m_pv || cons);
        logic [7:0] c = m_pd;
        m_ovf = (v && !cap) || (m_ovf && !clr);
        if (m_left > 0) m_left--;
        else if (cons) begin
            if (c >= 8'h20 && c <= 8'h7E) begin
                m_mem[m_row * COLS + m_col] = c;
                if (m_col == COLS - 1) newline();
                else m_col++;
            end else if (c == 8'h0A) newline();
            else if (c == 8'h0D) m_col = 0;
            else if (c == 8'h08) begin
                if (m_col > 0) begin
                    m_col--;
                    m_mem[m_row * COLS + m_col] = 8'h20;
                end
            end else if (c == 8'h0C) begin
                m_col = 0; m_row = 0;
                fill(0, CELLS);
                m_left = CELLS;
            end
        end
        if (cap) begin
            m_pv = 1; m_pd = d;
        end else if (cons) m_pv = 0;
    endfunction

    task automatic cyc(bit v, logic [7:0] d, bit clr, int addr);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1; bv = v; b = d; ovf_clr = clr; rd_addr = AW'(addr);
        e.rd_chk = (m_left == 0);
        e.rd = m_mem[addr];
        m_step(v, d, clr);
        e.col = m_col; e.row = m_row; e.busy = (m_left > 0); e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, $urandom_range(0, CELLS - 1));
    endtask

    task automatic send(logic [7:0] d);
        int n = 0;
        cyc(1, d, 0, $urandom_range(0, CELLS - 1));
        while ((m_left > 0 || m_pv) && n < 2000) begin
            idle(1);
            n++;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < CELLS; a++) cyc(0, 8'h00, 0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; bv = 1'b0; ovf_clr = 1'b0;
        m_reset();
        #1;
        check("reset_rd_data", rd_data, 0);
        check("reset_col", ccol, 0);
        check("reset_row", crow, 0);
        check("reset_busy", busy, 1);
        check("reset_ovf", ovf, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.rd_chk) check("rd_data", rd_data, e.rd);
            check("cursor_col", ccol, e.col);
            check("cursor_row", crow, e.row);
            check("busy", busy, e.busy);
            check("overflow", ovf, e.ovf);
        end
    end

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 78) return 8'h0A;
        if (r < 84) return 8'h0D;
        if (r < 92) return 8'h08;
        if (r < 93) return 8'h0C;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        do_reset();
        idle(600);
        read_all();
        // "Hi" with strobes 234 cycles apart, then read back addr 1 right behind the second write.
        cyc(1, 8'h48, 0, 0);
        idle(233);
        cyc(1, 8'h69, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1);
        idle(4);
        // Walk to (39,14) and type one more character to wrap the whole grid.
        for (int i = 0; i < 14; i++) send(8'h0A);
        for (int i = 0; i < 39; i++) send(8'($urandom_range(33, 126)));
        send(8'h5A);
        cyc(0, 8'h00, 0, CELLS - 1);
        for (int a = 0; a < COLS; a++) cyc(0, 8'h00, 0, a);
        // Backspace mid-row, then backspace at column 0.
        send(8'h41); send(8'h42); send(8'h08);
        for (int a = 0; a < 3; a++) cyc(0, 8'h00, 0, a);
        send(8'h0D); send(8'h08);
        for (int a = 0; a < 3; a++) cyc(0, 8'h00, 0, a);
        // Two bytes during a row clear: the second one overflows the skid.
        cyc(1, 8'h0A, 0, 0);
        idle(3);
        cyc(1, 8'h43, 0, 0);
        idle(4);
        cyc(1, 8'h44, 0, 0);
        idle(50);
        cyc(0, 8'h00, 1, 0);
        idle(3);
        // Form feed from mid-screen, reset halfway through its clear.
        send(8'h0A); send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'($urandom_range(33, 126)));
        cyc(1, 8'h0C, 0, 0);
        idle(300);
        cyc(1, 8'h45, 0, 0);
        cyc(1, 8'h46, 0, 0);
        do_reset();
        idle(600);
        read_all();
        // Random traffic, including bursts that collide with clears.
        for (int i = 0; i < 4000; i++)
            cyc(($urandom_range(0, 3) == 0), rand_byte(), ($urandom_range(0, 49) == 0),
                $urandom_range(0, CELLS - 1));
        idle(700);
        read_all();
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
